// File: rtl/sprite_slot_bank.sv
// sprite_slot_bank: double-buffered sprite descriptor slots; optional SPRITE_LINE_AUTOINC_EN adds line_tick auto-increment
module sprite_slot_bank #(
    parameter int NUM_SLOTS = 4,
    parameter int NUM_W     = 5,
    parameter int LINE_W    = 4,
    parameter int OFFS_W    = 5,
    localparam int DESC_W   = NUM_W + LINE_W + OFFS_W + 1,
    localparam int SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [SLOT_W-1:0]             wr_slot,
    input  logic [DESC_W-1:0]             wr_desc,
    output logic                          wr_err,
    input  logic                          commit,
    output logic                          commit_ack,
    output logic                          dirty,
`ifdef SPRITE_LINE_AUTOINC_EN
    input  logic                          line_tick,
`endif
    output logic [NUM_SLOTS*NUM_W-1:0]    sp_num,
    output logic [NUM_SLOTS*LINE_W-1:0]   sp_line,
    output logic [NUM_SLOTS*OFFS_W-1:0]   sp_offset,
    output logic [NUM_SLOTS-1:0]          sp_en
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] COPY = 1'b1;
    localparam logic [SLOT_W:0] SLOT_LIMIT = NUM_SLOTS[SLOT_W:0];
    localparam int LINE_LSB = NUM_W;
    localparam int EN_BIT = DESC_W - 1;

    logic [0:0]        state;
    logic [DESC_W-1:0] shadow [NUM_SLOTS];
    logic [DESC_W-1:0] active [NUM_SLOTS];
    logic              accept;
    logic              in_range;

    assign wr_ready = (state == IDLE) && !rst;
    assign accept   = wr_valid && wr_ready;
    assign in_range = {1'b0, wr_slot} < SLOT_LIMIT;

    // Shadow bank: accepted in-range writes land here, invisible until a copy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) shadow[i] <= '0;
        end else if (accept && in_range) begin
            shadow[wr_slot] <= wr_desc;
        end
    end

    // Active bank: atomic copy on leaving COPY; otherwise optional per-line advance
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) active[i] <= '0;
        end else if (state == COPY) begin
            for (int i = 0; i < NUM_SLOTS; i++) active[i] <= shadow[i];
`ifdef SPRITE_LINE_AUTOINC_EN
        end else if (line_tick) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (active[i][EN_BIT]) begin
                    active[i][LINE_LSB +: LINE_W] <= active[i][LINE_LSB +: LINE_W] + 1'b1;
                    if (&active[i][LINE_LSB +: LINE_W]) active[i][EN_BIT] <= 1'b0;
                end
            end
`endif
        end
    end

    // Control: IDLE/COPY sequencing, dirty tracking and registered status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dirty      <= 1'b0;
            wr_err     <= 1'b0;
            commit_ack <= 1'b0;
        end else begin
            state      <= (state == IDLE && commit) ? COPY : IDLE;
            wr_err     <= accept && !in_range;
            commit_ack <= state == COPY;
            dirty      <= (state == COPY) ? 1'b0 : (dirty || (accept && in_range));
        end
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_unpack
        assign sp_num[k*NUM_W +: NUM_W]     = active[k][0 +: NUM_W];
        assign sp_line[k*LINE_W +: LINE_W]  = active[k][LINE_LSB +: LINE_W];
        assign sp_offset[k*OFFS_W +: OFFS_W] = active[k][NUM_W+LINE_W +: OFFS_W];
        assign sp_en[k]                     = active[k][EN_BIT];
    end
endmodule
